// File: rtl/divider.sv
// divider: multicycle unsigned restoring divider, one quotient bit per clock,
// returning {remainder, quotient} with a busy/done handshake.
module divider #(
  parameter int WIDTH = 32,
  parameter logic [5:0] DIVU = 6'b011011
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  input  logic [5:0]         Signal,
  output logic [2*WIDTH-1:0] dataOut,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] r_q, r_d, out_q, out_d, t, r_step;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] diff;
  logic start, run, last;
  // R holds {partial remainder, dividend bits shifting out / quotient bits shifting in}
  always_comb begin
    t = r_q << 1;
    diff = {1'b0, t[2*WIDTH-1:WIDTH]} - {1'b0, d_q};
    r_step = diff[WIDTH] ? t : {diff[WIDTH-1:0], t[WIDTH-1:1], 1'b1};
    run = state_q == RUN;
    start = !run && Signal == DIVU;
    last = run && &cnt_q;
    state_d = start ? RUN : run ? (last ? DONE : RUN) : IDLE;
    r_d = start ? {{WIDTH{1'b0}}, dataA} : run ? r_step : r_q;
    d_d = start ? dataB : d_q;
    cnt_d = start ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    out_d = last ? r_step : out_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      r_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end
  assign dataOut = out_q;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed and random checks of divider against an arithmetic model.
module tb_divider;
  localparam logic [5:0] DIVU = 6'b011011;
  logic clk = 0;
  logic reset = 1;
  logic [31:0] dataA = 0, dataB = 0;
  logic [5:0] Signal = 0;
  logic [63:0] dataOut;
  logic busy, done;
  int vectors = 0, miscompares = 0;
  int m_cnt = 0;
  logic m_done = 0;
  logic [63:0] m_out = 0, m_pend = 0;

  divider dut (.clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .Signal(Signal),
               .dataOut(dataOut), .busy(busy), .done(done));

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: an accepted op occupies 32 clocks, then its result appears with a done pulse
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0;
      m_done <= 0;
      m_out <= 0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1;
        m_out <= m_pend;
      end
    end else begin
      m_done <= 0;
      if (Signal == DIVU) begin
        m_cnt <= 32;
        m_pend <= ref_div(dataA, dataB);
      end
    end
  end

  always @(posedge clk) begin
    #3;
    if (!reset) begin
      chk("busy", {63'b0, busy}, {63'b0, m_cnt != 0});
      chk("done", {63'b0, done}, {63'b0, m_done});
      chk("dataOut", dataOut, m_out);
    end
  end

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    Signal = DIVU;
    dataA = a;
    dataB = b;
    @(negedge clk);
    Signal = 0;
  endtask

  task automatic wait_done(input string nm, input logic [63:0] exp, input int cyc);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(cyc));
    chk(nm, dataOut, exp);
  endtask

  initial begin
    #12;
    chk("reset_out", dataOut, 64'd0);
    chk("reset_bd", {62'b0, busy, done}, 64'd0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    start(100, 7);
    wait_done("basic", {32'd2, 32'd14}, 32);
    @(negedge clk);
    start(32'hFFFFFFFF, 1);
    wait_done("max_by_1", {32'd0, 32'hFFFFFFFF}, 32);
    @(negedge clk);
    start(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("max_by_max", {32'd0, 32'd1}, 32);
    @(negedge clk);
    chk("idle_after_done", {62'b0, busy, done}, 64'd0);
    chk("hold_result", dataOut, {32'd0, 32'd1});
    start(5, 0);
    wait_done("div_zero", {32'd5, 32'hFFFFFFFF}, 32);
    @(negedge clk);
    start(50, 6);
    repeat (9) @(negedge clk);
    Signal = DIVU;
    dataA = 9;
    dataB = 2;
    @(negedge clk);
    Signal = 0;
    wait_done("ignore_busy", {32'd2, 32'd8}, 22);
    @(negedge clk);
    chk("no_second_start", {62'b0, busy, done}, 64'd0);
    start(1000, 3);
    repeat (14) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("async_rst_out", dataOut, 64'd0);
    chk("async_rst_bd", {62'b0, busy, done}, 64'd0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    start(1000, 3);
    wait_done("after_reset", {32'd1, 32'd333}, 32);
    @(negedge clk);
    start(3, 10);
    wait_done("a_lt_b", {32'd3, 32'd0}, 32);
    start(81, 9);
    chk("b2b_busy", {63'b0, busy}, 64'd1);
    wait_done("b2b_second", {32'd0, 32'd9}, 32);
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(31, 0);
      start(a, b);
      wait_done("random", ref_div(a, b), 32);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
